// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer divider with registered clk_out/tick strobes,
// shadowed divisor applied only at a period boundary.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             cfg_pending
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d, new_div;
  logic             pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d;
  logic             run, wrap, apply;
  // a stopped or disabled divider is itself a period boundary
  always_comb begin
    run       = en && (act_q != '0);
    wrap      = run && (cnt_q == act_q - ONE);
    apply     = (wrap || !run) && (pend_q || load);
    new_div   = load ? div_val : shd_q;
    act_d     = apply ? new_div : act_q;
    shd_d     = (apply || load) ? new_div : shd_q;
    pend_d    = apply ? 1'b0 : (load ? 1'b1 : pend_q);
    cnt_d     = (apply || wrap || act_q == '0) ? '0 : (run ? cnt_q + ONE : cnt_q);
    clk_out_d = run && (cnt_q < act_q - (act_q >> 1));
    tick_d    = wrap;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      act_q     <= DEF;
      shd_q     <= DEF;
      pend_q    <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pend_q    <= pend_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end
  assign clk_out     = clk_out_q;
  assign tick        = tick_q;
  assign count       = cnt_q;
  assign cfg_pending = pend_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed, self-checking bench for clk_div_prog.
module tb_clk_div_prog;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_val = '0;
  logic       clk_out, tick, cfg_pending;
  logic [7:0] count;
  int         n_run = 0;
  int         n_fail = 0;
  int         t3_cnt [10] = '{1, 2, 3, 0, 1, 2, 3, 4, 5, 0};
  int         t3_co  [10] = '{1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
  int         t3_tk  [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
  int         t3_pd  [10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div_val(div_val),
    .clk_out(clk_out), .tick(tick), .count(count), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int co, input int tk, input int pd);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".clk_out"}, 32'(clk_out), co);
    chk({tag, ".tick"}, 32'(tick), tk);
    chk({tag, ".pending"}, 32'(cfg_pending), pd);
  endtask

  initial begin
    #3;
    chk_all("reset", 0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    // default divide-by-2
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_all("div2", k % 2, k % 2, (k % 2 == 0) ? 1 : 0, 0);
    end
    // D=5 loaded while idle applies at once
    en = 1'b0; load = 1'b1; div_val = 8'd5;
    step();
    chk_all("d5_load", 0, 0, 0, 0);
    load = 1'b0;
    step();
    chk_all("d5_idle", 0, 0, 0, 0);
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk_all("d5_run", k % 5, ((k - 1) % 5 < 3) ? 1 : 0, (k % 5 == 0) ? 1 : 0, 0);
    end
    // switch to D=4 at the D=5 boundary
    load = 1'b1; div_val = 8'd4;
    step();
    chk_all("d4_load", 1, 1, 0, 1);
    load = 1'b0;
    repeat (4) step();
    chk_all("d4_apply", 0, 0, 1, 0);
    // load 6 at count=1 of a D=4 period
    div_val = 8'd6;
    for (int k = 0; k < 10; k++) begin
      load = (k == 1);
      step();
      chk_all("d4_to_d6", t3_cnt[k], t3_co[k], t3_tk[k], t3_pd[k]);
    end
    load = 1'b0;
    // establish D=8
    load = 1'b1; div_val = 8'd8;
    step();
    load = 1'b0;
    repeat (5) step();
    chk_all("d8_apply", 0, 0, 1, 0);
    repeat (2) step();
    load = 1'b1; div_val = 8'd3;
    step();
    chk_all("ovw_load3", 3, 1, 0, 1);
    load = 1'b0;
    step();
    load = 1'b1; div_val = 8'd5;
    step();
    load = 1'b0;
    repeat (2) step();
    chk_all("ovw_cnt7", 7, 0, 0, 1);
    step();
    chk_all("ovw_apply5", 0, 0, 1, 0);
    repeat (4) step();
    chk_all("d5_cnt4", 4, 0, 0, 0);
    // load coincident with the wrap cycle
    load = 1'b1; div_val = 8'd2;
    step();
    load = 1'b0;
    chk_all("coinc_apply", 0, 0, 1, 0);
    step();
    chk_all("coinc_d2a", 1, 1, 0, 0);
    step();
    chk_all("coinc_d2b", 0, 0, 1, 0);
    // divisor 0 stops the divider
    load = 1'b1; div_val = 8'd0;
    step();
    load = 1'b0;
    chk_all("d0_load", 1, 1, 0, 1);
    step();
    chk_all("d0_apply", 0, 0, 1, 0);
    repeat (2) begin
      step();
      chk_all("d0_stop", 0, 0, 0, 0);
    end
    // divisor 1 while stopped
    load = 1'b1; div_val = 8'd1;
    step();
    load = 1'b0;
    chk_all("d1_load", 0, 0, 0, 0);
    repeat (3) begin
      step();
      chk_all("d1_run", 0, 1, 1, 0);
    end
    // D=1 wraps every cycle so the load applies at once
    load = 1'b1; div_val = 8'd6;
    step();
    load = 1'b0;
    chk_all("d6_apply", 0, 1, 1, 0);
    repeat (3) step();
    chk_all("d6_cnt3", 3, 1, 0, 0);
    en = 1'b0;
    step();
    chk_all("freeze_a", 3, 0, 0, 0);
    step();
    chk_all("freeze_b", 3, 0, 0, 0);
    en = 1'b1;
    step();
    chk_all("resume4", 4, 0, 0, 0);
    step();
    chk_all("resume5", 5, 0, 0, 0);
    step();
    chk_all("resume0", 0, 0, 1, 0);
    step();
    load = 1'b1; div_val = 8'd4;
    step();
    load = 1'b0;
    chk_all("pre_rst", 2, 1, 0, 1);
    // asynchronous reset mid-period
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    step();
    chk_all("rst_held", 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk_all("post_rst1", 1, 1, 0, 0);
    step();
    chk_all("post_rst2", 0, 0, 1, 0);
    step();
    chk_all("post_rst3", 1, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider: the successor to the fixed divide-by-16 toggle divider. The division ratio is WIDTH bits wide. Ratio changes are glitch-free and take effect only at a period boundary. The block produces a near-50%-duty divided output plus a one-cycle tick strobe, and is used as a clock-enable/strobe generator for slower peripherals. All outputs are registered; nothing in the block is a generated clock tree.

## Interface
- WIDTH, 8: width of the divisor and the counter.
- DEFAULT_DIV, 2: active divisor after reset. Must be less than 2^WIDTH.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable. When low, the counter freezes and outputs drop.
- load  input  1  one-cycle strobe that captures div_val.
- div_val  input  WIDTH  requested divisor D.
- clk_out  output  1  divided output, high for ceil(D/2) of every D cycles.
- tick  output  1  one-cycle pulse per period, aligned to the last cycle of the period.
- count  output  WIDTH  current phase counter (0..D-1).
- cfg_pending  output  1  a loaded divisor is waiting for a period boundary.

## Operation
- **Registers**
  - cnt: phase counter.
  - d_act: active divisor.
  - d_shd: shadow divisor.
  - pending flag, clk_out, tick.
- **Reset values:** cnt=0, d_act=DEFAULT_DIV, d_shd=DEFAULT_DIV, pending=0, clk_out=0, tick=0, count=0.
- **Counting** (en=1, d_act≥1): cnt advances 0,1,…,d_act−1 and then wraps to 0. The wrap cycle is the one where cnt==d_act−1.
- **Output decode:** each enabled cycle registers
  - clk_out <= (cnt < ceil(d_act/2)), where ceil(d_act/2) = d_act − (d_act>>1)
  - tick <= (cnt == d_act−1)
- **Resulting waveform:** D=4 gives 2 high / 2 low; D=5 gives 3 high / 2 low.
- **d_act == 1:** cnt stays 0, clk_out is held 1, and tick fires every cycle.
- **d_act == 0:** divider stopped. cnt held at 0, clk_out=0, tick=0.
- **en == 0:** cnt holds its value, and clk_out and tick are registered 0. When en returns to 1, counting resumes from the held cnt.
- **Load:** load=1 captures div_val into d_shd and sets pending. A second load while pending overwrites d_shd; the last value wins.
- **Apply:** d_act<=d_shd, cnt<=0, pending<=0. Apply happens at the first of:
  - an enabled wrap cycle;
  - any cycle with en=0;
  - any cycle with d_act==0.
- **Load coincident with an apply cycle:** div_val from that same cycle is applied directly, bypassing the stale shadow, and pending ends 0.
- **Arithmetic width:** all comparisons are WIDTH-bit unsigned. d_act−1 is evaluated only when d_act≥1.
- count is a direct copy of cnt.

## Timing
- clk_out and tick lag the cnt value they decode by exactly one cycle.
- With DEFAULT_DIV=2, en=1 from the first cycle after reset release:
  - cnt: 0,1,0,1…
  - clk_out: 0,1,0,1,0…, i.e. the first high is in cycle 2.
- **Reconfiguration:** the new period starts at cnt=0 on the cycle after the apply cycle. No shortened or stretched high phase is ever emitted mid-period.
- cfg_pending rises the cycle after load and falls the cycle after apply.
- **Reset asserted mid-operation:** all registers return immediately to their reset values, independent of clk. A pending divisor is discarded.
- Reset deassertion is assumed synchronised upstream.

## Test plan
1. **Reset and default divide-by-2.** Reset, then en=1 with defaults. Required: clk_out 0,1,0,1…; tick high every 2nd cycle, coincident with clk_out=0; count alternates 0,1.
2. **Odd divisor D=5 from idle.** load with div_val=5 while en=0, then en=1. Required: clk_out repeats 1,1,1,0,0; tick pulses once every 5 cycles; cfg_pending clears one cycle after load.
3. **Boundary-aligned reconfiguration.** Running D=4, load with div_val=6 when count=1. Required:
   - cfg_pending stays 1 until count reaches 3;
   - the current period completes as 2 high / 2 low;
   - the next period is 3 high / 3 low;
   - no glitch appears on clk_out.
4. **Load overwrite and coincident load.**
   - Running D=8: load 3 at count=2, then load 5 at count=4. Required: D=5 applies after count=7.
   - Then load 2 exactly at count=4 (the D=5 wrap cycle). Required: D=2 applies immediately and cfg_pending stays 0.
5. **Edge divisors.** Load 0. Required: clk_out=0, tick=0, count=0 held. Load 1 while stopped. Required: applies on the next cycle; clk_out held 1 and tick every cycle.
6. **Enable freeze and async reset.**
   - Running D=6: drop en at count=3. Required: count holds 3, clk_out and tick go 0. Restore en. Required: count resumes 4,5,0.
   - Assert rst mid-period with cfg_pending=1. Required: all outputs reset immediately and d_act returns to DEFAULT_DIV.
